// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the 5-stage core hazard control:
//                forwarding-select codes, the hazard FSM state encoding
//                and the hardwired-zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM result

    // $zero is hardwired; a write to it must never be forwarded
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Hazard FSM state encoding
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_RESUME = 2'd2
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Forwarding select for one EX operand. MEM result has
//                priority over WB result; register 0 never forwards.
//  Ports       : src_addr      - register read by the EX operand
//                mem_wr_addr   - EX/MEM destination register
//                mem_reg_write - EX/MEM RegWrite
//                wb_wr_addr    - MEM/WB destination register
//                wb_reg_write  - MEM/WB RegWrite
//                sel           - FWD_MEM / FWD_WB / FWD_NONE
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic [4:0] mem_wr_addr,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_wr_addr,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = mem_reg_write && (mem_wr_addr != REG_ZERO) && (mem_wr_addr == src_addr);
    assign w_wb_hit  = wb_reg_write  && (wb_wr_addr  != REG_ZERO) && (wb_wr_addr  == src_addr);

    always_comb begin
        sel = FWD_NONE;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard control for the 5-stage core. Decides each
//                cycle whether IF/ID/EX advance, bubble, flush or freeze;
//                produces EX forwarding selects, tracks cache-miss freeze
//                state, and keeps saturating stall/flush counters plus a
//                sticky freeze watchdog.
//  Ports       : clk, rst_n (async, active-low)
//                id_*         - ID-stage source registers
//                ex_*         - ID/EX source registers and load flag
//                mem_*, wb_*  - EX/MEM and MEM/WB write-back info
//                br_taken_ex  - branch in EX resolved taken
//                icache_stall, dcache_stall - cache miss pending
//                pc_hold, ifid_hold, idex_bubble, flush, freeze - controls
//                fwd_a, fwd_b - EX operand selects
//                stall_cnt, flush_cnt, frz_timeout - status
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int FRZ_MAX = 255
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs_addr,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_wr_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_wr_addr,
    input  logic             wb_reg_write,
    input  logic             br_taken_ex,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             frz_timeout
);

    localparam int               c_FRZ_W   = (FRZ_MAX < 2) ? 1 : $clog2(FRZ_MAX + 1);
    localparam logic [c_FRZ_W-1:0] c_FRZ_LIM = c_FRZ_W'(FRZ_MAX);
    localparam logic [c_FRZ_W-1:0] c_FRZ_ONE = c_FRZ_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    hz_state_t          r_state;
    logic               r_pend_flush;
    logic [c_FRZ_W-1:0] r_frz_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_frz_timeout;

    logic               w_cache_stall;
    logic               w_freeze;
    logic               w_flush;
    logic               w_load_use;
    logic               w_bubble;
    logic [c_FRZ_W-1:0] w_frz_next;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    // ------------------------------------------------------------------
    // Per-cycle control. Every output is forced low while rst_n is low,
    // even though the cache/branch inputs may still be asserted.
    // Priority: freeze > flush > load-use bubble.
    // ------------------------------------------------------------------
    assign w_cache_stall = icache_stall | dcache_stall;
    assign w_freeze      = rst_n & w_cache_stall;

    // A branch resolved during a freeze is remembered and the flush is
    // issued in the first cycle the pipeline moves again.
    assign w_flush = rst_n & ~w_freeze & (br_taken_ex | r_pend_flush);

    assign w_load_use = ex_mem_read && (ex_rt_addr != REG_ZERO) &&
                        ((ex_rt_addr == id_rs_addr) ||
                         (id_uses_rt && (ex_rt_addr == id_rt_addr)));

    assign w_bubble = rst_n & ~w_freeze & ~w_flush & w_load_use;

    assign freeze      = w_freeze;
    assign flush       = w_flush;
    assign pc_hold     = w_bubble;
    assign ifid_hold   = w_bubble;
    assign idex_bubble = w_bubble;

    // ------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------
    fwd_sel u_fwd_a (
        .src_addr      (ex_rs_addr),
        .mem_wr_addr   (mem_wr_addr),
        .mem_reg_write (mem_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .sel           (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_addr      (ex_rt_addr),
        .mem_wr_addr   (mem_wr_addr),
        .mem_reg_write (mem_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .sel           (w_fwd_b)
    );

    assign fwd_a = rst_n ? w_fwd_a : FWD_NONE;
    assign fwd_b = rst_n ? w_fwd_b : FWD_NONE;

    // Consecutive-freeze count for the watchdog, saturating at the limit
    always_comb begin
        w_frz_next = '0;
        if (w_freeze) begin
            if (r_frz_cnt != c_FRZ_LIM) begin
                w_frz_next = r_frz_cnt + c_FRZ_ONE;
            end else begin
                w_frz_next = c_FRZ_LIM;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, pending flush, counters, watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pend_flush  <= 1'b0;
            r_frz_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_frz_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:    r_state <= w_cache_stall ? ST_FREEZE : ST_RUN;
                ST_FREEZE: r_state <= w_cache_stall ? ST_FREEZE : ST_RESUME;
                ST_RESUME: r_state <= w_cache_stall ? ST_FREEZE : ST_RUN;
                default:   r_state <= ST_RUN;
            endcase

            if (w_freeze) begin
                if (br_taken_ex) begin
                    r_pend_flush <= 1'b1;
                end
            end else begin
                r_pend_flush <= 1'b0;
            end

            if ((w_freeze || w_bubble) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end

            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end

            r_frz_cnt <= w_frz_next;
            if (w_frz_next == c_FRZ_LIM) begin
                r_frz_timeout <= 1'b1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign frz_timeout = r_frz_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W   = 32;
    localparam int FRZ_MAX = 255;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic [4:0]       ex_rs_addr;
    logic [4:0]       ex_rt_addr;
    logic             ex_mem_read;
    logic [4:0]       mem_wr_addr;
    logic             mem_reg_write;
    logic [4:0]       wb_wr_addr;
    logic             wb_reg_write;
    logic             br_taken_ex;
    logic             icache_stall;
    logic             dcache_stall;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             flush;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             frz_timeout;

    int n_pass;
    int n_total;

    hazard_ctrl #(.CNT_W(CNT_W), .FRZ_MAX(FRZ_MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_uses_rt    (id_uses_rt),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .ex_mem_read   (ex_mem_read),
        .mem_wr_addr   (mem_wr_addr),
        .mem_reg_write (mem_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .br_taken_ex   (br_taken_ex),
        .icache_stall  (icache_stall),
        .dcache_stall  (dcache_stall),
        .pc_hold       (pc_hold),
        .ifid_hold     (ifid_hold),
        .idex_bubble   (idex_bubble),
        .flush         (flush),
        .freeze        (freeze),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .frz_timeout   (frz_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // a further 1 time unit later, well away from either clock edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rt = 1'b0;
        ex_rs_addr = 5'd0; ex_rt_addr = 5'd0; ex_mem_read = 1'b0;
        mem_wr_addr = 5'd0; mem_reg_write = 1'b0;
        wb_wr_addr = 5'd0; wb_reg_write = 1'b0;
        br_taken_ex = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        ctl = {pc_hold, ifid_hold, idex_bubble, flush, freeze, fwd_a, fwd_b};
        n_total++;
        if (ctl !== 9'd0) $display("FAIL reset_ctl: got %b want %b", ctl, 9'd0);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || frz_timeout !== 1'b0)
            $display("FAIL reset_status: got stall=%0d flush=%0d to=%b want 0/0/0",
                     stall_cnt, flush_cnt, frz_timeout);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        // lw $2 in EX, add in ID reads rs = $2
        ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd2; id_rt_addr = 5'd3;
        id_uses_rt = 1'b1;
        #1;
        n_total++;
        if ({pc_hold, ifid_hold, idex_bubble} !== 3'b111)
            $display("FAIL lu_bubble: got %b want 111", {pc_hold, ifid_hold, idex_bubble});
        else n_pass++;
        step();
        n_total++;
        if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
        else n_pass++;
        // Load has moved to MEM
        ex_mem_read = 1'b0; ex_rt_addr = 5'd4;
        #1;
        n_total++;
        if ({pc_hold, ifid_hold, idex_bubble} !== 3'b000)
            $display("FAIL lu_next: got %b want 000", {pc_hold, ifid_hold, idex_bubble});
        else n_pass++;
        step();
        n_total++;
        if (stall_cnt !== 32'd1) $display("FAIL lu_next_cnt: got %0d want 1", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use_rt();
        // ID rt matches but the instruction does not read rt
        ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd5; id_rt_addr = 5'd2;
        id_uses_rt = 1'b0;
        #1;
        n_total++;
        if (idex_bubble !== 1'b0) $display("FAIL lu_rt_unused: got %b want 0", idex_bubble);
        else n_pass++;
        id_uses_rt = 1'b1;
        #1;
        n_total++;
        if (idex_bubble !== 1'b1) $display("FAIL lu_rt_used: got %b want 1", idex_bubble);
        else n_pass++;
        step();   // stall_cnt -> 2
        // Load into $zero never stalls
        ex_rt_addr = 5'd0; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
        #1;
        n_total++;
        if ({pc_hold, idex_bubble} !== 2'b00)
            $display("FAIL lu_zero: got %b want 00", {pc_hold, idex_bubble});
        else n_pass++;
        step();
        n_total++;
        if (stall_cnt !== 32'd2) $display("FAIL lu_rt_cnt: got %0d want 2", stall_cnt);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_flush_priority();
        ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd2; br_taken_ex = 1'b1;
        #1;
        n_total++;
        if ({flush, idex_bubble, pc_hold, ifid_hold} !== 4'b1000)
            $display("FAIL flush_prio: got %b want 1000", {flush, idex_bubble, pc_hold, ifid_hold});
        else n_pass++;
        step();
        n_total++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2)
            $display("FAIL flush_cnt: got flush=%0d stall=%0d want 1/2", flush_cnt, stall_cnt);
        else n_pass++;
        clear_inputs();
        #1;
        n_total++;
        if (flush !== 1'b0) $display("FAIL flush_pulse: got %b want 0", flush);
        else n_pass++;
        step();
    endtask

    task automatic test_freeze_flush();
        int bad = 0;
        dcache_stall = 1'b1; br_taken_ex = 1'b1;
        // A load-use pattern during the freeze must not bubble either
        ex_mem_read = 1'b1; ex_rt_addr = 5'd6; id_rs_addr = 5'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({freeze, flush, pc_hold, idex_bubble} !== 4'b1000) bad++;
            step();
        end
        n_total++;
        if (bad != 0) $display("FAIL frz_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 32'd7) $display("FAIL frz_stall_cnt: got %0d want 7", stall_cnt);
        else n_pass++;
        clear_inputs();
        #1;
        n_total++;
        if ({freeze, flush} !== 2'b01)
            $display("FAIL frz_pend_flush: got %b want 01", {freeze, flush});
        else n_pass++;
        step();
        n_total++;
        if (flush !== 1'b0 || flush_cnt !== 32'd2)
            $display("FAIL frz_flush_once: got flush=%b cnt=%0d want 0/2", flush, flush_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_forwarding();
        mem_wr_addr = 5'd7; wb_wr_addr = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        ex_rs_addr = 5'd7; ex_rt_addr = 5'd7;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL fwd_mem: got %b want 1010", {fwd_a, fwd_b});
        else n_pass++;
        mem_reg_write = 1'b0;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0101) $display("FAIL fwd_wb: got %b want 0101", {fwd_a, fwd_b});
        else n_pass++;
        mem_reg_write = 1'b1; mem_wr_addr = 5'd0; wb_wr_addr = 5'd0;
        ex_rs_addr = 5'd0; ex_rt_addr = 5'd0;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL fwd_zero: got %b want 0000", {fwd_a, fwd_b});
        else n_pass++;
        // Mixed: A hits MEM, B hits WB only
        mem_wr_addr = 5'd9; wb_wr_addr = 5'd12; ex_rs_addr = 5'd9; ex_rt_addr = 5'd12;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b1001) $display("FAIL fwd_mix: got %b want 1001", {fwd_a, fwd_b});
        else n_pass++;
        clear_inputs();
        step();
    endtask

    task automatic test_watchdog();
        icache_stall = 1'b1;
        for (int i = 0; i < FRZ_MAX - 1; i++) step();
        n_total++;
        if (frz_timeout !== 1'b0) $display("FAIL wd_early: got %b want 0", frz_timeout);
        else n_pass++;
        step();
        n_total++;
        if (frz_timeout !== 1'b1) $display("FAIL wd_set: got %b want 1", frz_timeout);
        else n_pass++;
        // Leave a flush pending, then reset mid-freeze
        br_taken_ex = 1'b1;
        step();
        br_taken_ex = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({freeze, flush, pc_hold, fwd_a, fwd_b, frz_timeout} !== 8'd0 ||
            stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL wd_reset: got ctl=%b stall=%0d flush=%0d want 0/0/0",
                     {freeze, flush, pc_hold, fwd_a, fwd_b, frz_timeout}, stall_cnt, flush_cnt);
        else n_pass++;
        step();
        icache_stall = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({freeze, flush} !== 2'b00)
            $display("FAIL wd_pend_dropped: got %b want 00", {freeze, flush});
        else n_pass++;
        step();
        n_total++;
        if (flush_cnt !== 32'd0 || frz_timeout !== 1'b0)
            $display("FAIL wd_after: got flush=%0d to=%b want 0/0", flush_cnt, frz_timeout);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_load_use();
        test_load_use_rt();
        test_flush_priority();
        test_freeze_flush();
        test_forwarding();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
